// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC generation with valid/ready handshake, redirect buffering and stale-fetch flush
module pc_fetch_ctrl #(
  parameter int CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [CPU_WIDTH-1:0] pc_o,
  output logic                 pc_valid_o,
  input  logic                 pc_ready_i,
  output logic                 flush_o,
  input  logic                 br_valid_i,
  input  logic [CPU_WIDTH-1:0] br_target_i,
  input  logic                 mret_valid_i,
  input  logic [CPU_WIDTH-1:0] mret_target_i,
  input  logic                 exc_valid_i,
  input  logic [CPU_WIDTH-1:0] exc_target_i,
  input  logic                 halt_i,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] fetch_cnt_o
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t               r_state;
  logic [CPU_WIDTH-1:0] r_pc;
  logic [CPU_WIDTH-1:0] r_pend_tgt;
  logic                 r_pend;
  logic                 r_valid;
  logic                 r_halted;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_fire;
  logic                 w_redir;
  logic [CPU_WIDTH-1:0] w_sel;
  logic [CPU_WIDTH-1:0] w_tgt;
  logic                 w_flush;
  // redirect priority (trap over mret over branch), word-aligned target, and flush decision
  always_comb begin
    w_fire  = r_valid & pc_ready_i;
    w_redir = exc_valid_i | mret_valid_i | br_valid_i;
    w_sel   = exc_valid_i ? exc_target_i : mret_valid_i ? mret_target_i : br_target_i;
    w_tgt   = {w_sel[CPU_WIDTH-1:2], 2'b00};
    w_flush = w_fire & (w_redir | r_pend);
  end
  // state machine: PC, pending redirect, valid/halted flags and fetch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_pend_tgt <= '0;
      r_pend     <= 1'b0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= halt_i ? HALT : RUN;
          r_valid <= ~halt_i;
          r_halted <= halt_i;
          if (w_redir) r_pc <= w_tgt;
        end
        RUN: begin
          if (w_fire && !w_flush) r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (halt_i) begin
            r_state  <= HALT;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
            r_pend   <= 1'b0;
          end else if (w_fire) begin
            r_pc   <= w_redir ? w_tgt : r_pend ? r_pend_tgt : r_pc + CPU_WIDTH'(4);
            r_pend <= 1'b0;
          end else if (w_redir) begin
            r_pend     <= 1'b1;
            r_pend_tgt <= w_tgt;
          end
        end
        default: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
      endcase
    end
  end
  assign pc_o        = r_pc;
  assign pc_valid_o  = r_valid;
  assign halted_o    = r_halted;
  assign fetch_cnt_o = r_cnt;
  assign flush_o     = w_flush;
endmodule
